// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: instruction port, data port and shared memory bus of the arbiter.
interface mem_arbiter_if;
  logic        i_read;
  logic [31:0] i_addr;
  logic        i_resp;
  logic [31:0] i_rdata;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_mbe;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_resp;
  logic [31:0] d_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  modport slave (
    input  i_read, i_addr, d_read, d_write, d_mbe, d_addr, d_wdata, mem_resp, mem_rdata,
    output i_resp, i_rdata, d_resp, d_rdata, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
  );
  modport master (
    output i_read, i_addr, d_read, d_write, d_mbe, d_addr, d_wdata, mem_resp, mem_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction and a data requester.
module mem_arbiter #(
  parameter int FAIR = 1
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_e;
  state_e      state_q, state_d;
  logic        last_d_q, last_d_d;
  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic        i_resp_q, i_resp_d, d_resp_q, d_resp_d;
  logic [3:0]  mbe_q, mbe_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic        d_req, pick_d, grant, busy_resp;
  assign d_req     = bus.d_read | bus.d_write;
  // last_d_q=0 means instruction was granted last, so data wins a tie
  assign pick_d    = d_req & (~bus.i_read | (FAIR == 0) | ~last_d_q);
  assign grant     = (state_q == IDLE) & (bus.i_read | d_req);
  assign busy_resp = ((state_q == I_BUSY) | (state_q == D_BUSY)) & bus.mem_resp;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mbe_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mbe_q       <= mbe_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      i_resp_q    <= i_resp_d;
      d_resp_q    <= d_resp_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    if (grant) begin
      state_d  = pick_d ? D_BUSY : I_BUSY;
      last_d_d = pick_d;
    end else if (busy_resp) begin
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // a simultaneous data read+write is issued as a write
  always_comb begin
    mem_read_d  = grant ? (~pick_d | (bus.d_read & ~bus.d_write)) : busy_resp ? 1'b0 : mem_read_q;
    mem_write_d = grant ? (pick_d & bus.d_write) : busy_resp ? 1'b0 : mem_write_q;
    mbe_d       = grant ? (pick_d ? bus.d_mbe : 4'hF) : mbe_q;
    addr_d      = grant ? (pick_d ? bus.d_addr : bus.i_addr) : addr_q;
    wdata_d     = grant ? (pick_d ? bus.d_wdata : 32'h0) : wdata_q;
    i_resp_d    = busy_resp & (state_q == I_BUSY);
    d_resp_d    = busy_resp & (state_q == D_BUSY);
    i_rdata_d   = i_resp_d ? bus.mem_rdata : i_rdata_q;
    d_rdata_d   = (d_resp_d & mem_read_q) ? bus.mem_rdata : d_rdata_q;
  end
  assign bus.mem_read        = mem_read_q;
  assign bus.mem_write       = mem_write_q;
  assign bus.mem_byte_enable = mbe_q;
  assign bus.mem_address     = addr_q;
  assign bus.mem_wdata       = wdata_q;
  assign bus.i_resp          = i_resp_q;
  assign bus.i_rdata         = i_rdata_q;
  assign bus.d_resp          = d_resp_q;
  assign bus.d_rdata         = d_rdata_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter FAIR, default 1, meaning: 1 = round-robin arbitration, 0 = fixed data-port priority.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-low reset
- i_read  input  1  instruction-port read request
- i_addr  input  32  instruction-port address
- i_resp  output  1  instruction-port response pulse
- i_rdata  output  32  instruction-port read data
- d_read  input  1  data-port read request
- d_write  input  1  data-port write request
- d_mbe  input  4  data-port byte enable
- d_addr  input  32  data-port address
- d_wdata  input  32  data-port write data
- d_resp  output  1  data-port response pulse
- d_rdata  output  32  data-port read data
- mem_read  output  1  shared memory read strobe
- mem_write  output  1  shared memory write strobe
- mem_byte_enable  output  4  shared memory byte enable
- mem_address  output  32  shared memory address
- mem_wdata  output  32  shared memory write data
- mem_resp  input  1  shared memory response
- mem_rdata  input  32  shared memory read data

Function
REQ-003 All outputs SHALL be registered.
REQ-004 FSM states SHALL be IDLE, I_BUSY, D_BUSY, DONE.
REQ-005 In IDLE, arbitration:
- no request -> stay in IDLE
- only i_read -> I_BUSY
- only d_read/d_write -> D_BUSY
- both ports requesting, FAIR=0 -> D_BUSY
- both ports requesting, FAIR=1 -> grant the port not granted last
REQ-006 A last_grant register SHALL update on each grant, and reset to "instruction" so data wins the first tie.
REQ-007 On the grant edge, the block SHALL capture the winning port's address, mbe and wdata into the mem_* output registers and assert mem_read or mem_write.
- Instruction grant: mem_byte_enable=4'hF, mem_wdata=0, mem_write=0.
REQ-008 If d_read and d_write are both high, the block SHALL treat the request as a write (mem_write=1, mem_read=0).
REQ-009 In I_BUSY/D_BUSY, the mem_* outputs SHALL hold constant until a cycle with mem_resp=1.
REQ-010 On mem_resp in I_BUSY/D_BUSY, the block SHALL:
- deassert mem_read/mem_write,
- capture mem_rdata into the granted port's rdata register,
- move to DONE.
REQ-011 In DONE, the block SHALL assert exactly one of i_resp/d_resp (the granted port) for one cycle, ignore all requests, and return to IDLE.
REQ-012 Latency: a request sampled in IDLE at cycle t SHALL give mem strobe at t+1; mem_resp at t+1+k SHALL give port resp at t+2+k and IDLE at t+3+k.
- Minimum total is 3 cycles (k=0 means mem_resp in the first strobe cycle).
REQ-013 i_rdata/d_rdata SHALL hold their last captured value until the next response to that port, including after writes (d_rdata unchanged on a write).
REQ-014 A mem_resp received in IDLE or DONE SHALL be ignored.
REQ-015 Requesters SHALL hold request and address stable until their resp; a request still asserted in the resp cycle is re-arbitrated in IDLE the next cycle.
REQ-016 The non-granted port's request SHALL remain pending, with no loss and no resp, until it is granted.

Reset
REQ-017 While rst=0 at a clock edge, the block SHALL:
- enter IDLE, last_grant=instruction,
- set every output to 0 (mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, i_resp, d_resp, i_rdata, d_rdata).
REQ-018 Reset asserted mid-transaction SHALL abandon the transaction with no resp issued; a late mem_resp afterward is ignored per REQ-014.

Verification
REQ-019 Scenario: i_read=1, i_addr=0x60 in IDLE; mem_resp on the 3rd strobe cycle with mem_rdata=0x00A00093 -> mem_read=1, mem_address=0x60, mbe=4'hF for 3 cycles; i_resp=1 for one cycle with i_rdata=0x00A00093.
REQ-020 Scenario: both ports request after reset (d_write, d_addr=0x100, d_mbe=4'b0011, d_wdata=0xBEEF), FAIR=1 -> data granted first (mem_write=1, mbe=0011), then instruction; FAIR=0 with d_write kept high -> data granted repeatedly and instruction starves.
REQ-021 Scenario: d_read and d_write both high -> mem_write=1, mem_read=0, d_resp one pulse, d_rdata unchanged.
REQ-022 Scenario: rst=0 while in D_BUSY, then mem_resp=1 the cycle after reset release -> all outputs 0, no d_resp, state IDLE.
REQ-023 Scenario: mem_resp=1 with no request pending -> no resp pulse, outputs unchanged.
REQ-024 Scenario: back-to-back i_read held high through i_resp -> second mem_read begins exactly 2 cycles after the first i_resp cycle.
